// File: rtl/cash_dispenser.sv
// Greedy 200/100/50 note planner and one-note-at-a-time feeder; optional refill input under DISP_REFILL_EN.
// Latency: CHECK 1 cycle, PLAN one note per cycle; the feeder holds note_req until note_ack or ACK_TIMEOUT.
module cash_dispenser #(
  parameter int BALANCE_WIDTH = 20,
  parameter int CNT_WIDTH     = 8,
  parameter int NOTES_INIT    = 100,
  parameter int MAX_AMOUNT    = 2000,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef DISP_REFILL_EN
  input  logic                     refill,
`endif
  input  logic                     dispense_req,
  input  logic [BALANCE_WIDTH-1:0] amount,
  input  logic                     note_ack,
  output logic                     note_req,
  output logic [1:0]               note_sel,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [1:0]               error_code,
  output logic [CNT_WIDTH-1:0]     avail_200,
  output logic [CNT_WIDTH-1:0]     avail_100,
  output logic [CNT_WIDTH-1:0]     avail_50
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [BALANCE_WIDTH-1:0] D200       = BALANCE_WIDTH'(200);
  localparam logic [BALANCE_WIDTH-1:0] D100       = BALANCE_WIDTH'(100);
  localparam logic [BALANCE_WIDTH-1:0] D50        = BALANCE_WIDTH'(50);
  localparam logic [BALANCE_WIDTH-1:0] AMT_MAX    = BALANCE_WIDTH'(MAX_AMOUNT);
  localparam logic [CNT_WIDTH-1:0]     STOCK_INIT = CNT_WIDTH'(NOTES_INIT);
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [TMO_W-1:0]         TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]         TMO_ONE    = TMO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PLAN,
    S_DISPENSE,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t                   state;
  logic [BALANCE_WIDTH-1:0] rem;
  logic [CNT_WIDTH-1:0]     plan_200;
  logic [CNT_WIDTH-1:0]     plan_100;
  logic [CNT_WIDTH-1:0]     plan_50;
  logic [TMO_W-1:0]         tmo_cnt;

  logic       can_200;
  logic       can_100;
  logic       can_50;
  logic       plan_empty;
  logic [1:0] first_sel;
  logic       refill_now;

  // A denomination is pickable only while stock still covers what is already planned.
  always_comb begin
    can_200    = (rem >= D200) && (plan_200 < avail_200);
    can_100    = (rem >= D100) && (plan_100 < avail_100);
    can_50     = (rem >= D50)  && (plan_50  < avail_50);
    plan_empty = (plan_200 == '0) && (plan_100 == '0) && (plan_50 == '0);
    first_sel  = 2'd2;
    if (plan_200 != '0) begin
      first_sel = 2'd0;
    end else if (plan_100 != '0) begin
      first_sel = 2'd1;
    end
  end

`ifdef DISP_REFILL_EN
  assign refill_now = refill && (state == S_IDLE);
`else
  assign refill_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rem        <= '0;
      plan_200   <= '0;
      plan_100   <= '0;
      plan_50    <= '0;
      tmo_cnt    <= '0;
      note_req   <= 1'b0;
      note_sel   <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      error_code <= 2'd0;
      avail_200  <= STOCK_INIT;
      avail_100  <= STOCK_INIT;
      avail_50   <= STOCK_INIT;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;

      // Refill lands on the same edge as an accept, so PLAN sees the new stock.
      if (refill_now) begin
        avail_200 <= STOCK_INIT;
        avail_100 <= STOCK_INIT;
        avail_50  <= STOCK_INIT;
      end

      case (state)
        S_IDLE: begin
          if (dispense_req) begin
            rem        <= amount;
            plan_200   <= '0;
            plan_100   <= '0;
            plan_50    <= '0;
            error_code <= 2'd0;
            busy       <= 1'b1;
            state      <= S_CHECK;
          end
        end

        S_CHECK: begin
          if ((rem == '0) || (rem > AMT_MAX)) begin
            error_code <= 2'd1;
            fail       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_ERR;
          end else begin
            state <= S_PLAN;
          end
        end

        S_PLAN: begin
          if (can_200) begin
            rem      <= rem - D200;
            plan_200 <= plan_200 + CNT_ONE;
          end else if (can_100) begin
            rem      <= rem - D100;
            plan_100 <= plan_100 + CNT_ONE;
          end else if (can_50) begin
            rem     <= rem - D50;
            plan_50 <= plan_50 + CNT_ONE;
          end else if (rem == '0) begin
            note_req <= 1'b1;
            note_sel <= first_sel;
            tmo_cnt  <= '0;
            state    <= S_DISPENSE;
          end else begin
            error_code <= 2'd2;
            fail       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_ERR;
          end
        end

        S_DISPENSE: begin
          if (note_req && note_ack) begin
            case (note_sel)
              2'd0: begin
                plan_200  <= plan_200 - CNT_ONE;
                avail_200 <= avail_200 - CNT_ONE;
              end
              2'd1: begin
                plan_100  <= plan_100 - CNT_ONE;
                avail_100 <= avail_100 - CNT_ONE;
              end
              2'd2: begin
                plan_50  <= plan_50 - CNT_ONE;
                avail_50 <= avail_50 - CNT_ONE;
              end
              default: ;
            endcase
            note_req <= 1'b0;
            state    <= S_GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            note_req   <= 1'b0;
            error_code <= 2'd3;
            fail       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end

        S_GAP: begin
          if (plan_empty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            note_req <= 1'b1;
            note_sel <= first_sel;
            tmo_cnt  <= '0;
            state    <= S_DISPENSE;
          end
        end

        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cash_dispenser.sv
// Randomized bench for cash_dispenser against a bulk-arithmetic greedy model of the cassettes.
module tb_cash_dispenser;

  localparam int BW   = 20;
  localparam int CW   = 8;
  localparam int NI   = 100;
  localparam int MAXA = 2000;
  localparam int TMO  = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dispense_req;
  logic [BW-1:0] amount;
  logic          note_ack;
  logic          note_req;
  logic [1:0]    note_sel;
  logic          busy;
  logic          done;
  logic          fail;
  logic [1:0]    error_code;
  logic [CW-1:0] avail_200;
  logic [CW-1:0] avail_100;
  logic [CW-1:0] avail_50;
`ifdef DISP_REFILL_EN
  logic          refill;
`endif

  cash_dispenser #(
    .BALANCE_WIDTH(BW), .CNT_WIDTH(CW), .NOTES_INIT(NI),
    .MAX_AMOUNT(MAXA), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef DISP_REFILL_EN
    .refill(refill),
`endif
    .dispense_req(dispense_req),
    .amount(amount),
    .note_ack(note_ack),
    .note_req(note_req),
    .note_sel(note_sel),
    .busy(busy),
    .done(done),
    .fail(fail),
    .error_code(error_code),
    .avail_200(avail_200),
    .avail_100(avail_100),
    .avail_50(avail_50)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int denom[3] = '{200, 100, 50};
  int model_avail[3];
  int exp_seq[$];
  int exp_code;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Greedy in bulk: take as many of each denomination as both amount and stock allow.
  function automatic void model_plan(input int amt);
    int rem;
    int n;
    rem = amt;
    exp_seq.delete();
    if (amt == 0 || amt > MAXA) begin
      exp_code = 1;
      return;
    end
    for (int d = 0; d < 3; d++) begin
      n = rem / denom[d];
      if (n > model_avail[d]) n = model_avail[d];
      rem -= n * denom[d];
      for (int k = 0; k < n; k++) exp_seq.push_back(d);
    end
    if (rem != 0) begin
      exp_seq.delete();
      exp_code = 2;
    end else begin
      exp_code = 0;
    end
  endfunction

  function automatic int dut_avail(input int d);
    case (d)
      0:       return int'(avail_200);
      1:       return int'(avail_100);
      default: return int'(avail_50);
    endcase
  endfunction

  task automatic check_stock(input string tag);
    check_eq({tag, "_avail_200"}, avail_200, model_avail[0]);
    check_eq({tag, "_avail_100"}, avail_100, model_avail[1]);
    check_eq({tag, "_avail_50"},  avail_50,  model_avail[2]);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_note_req"},   note_req,   0);
    check_eq({tag, "_note_sel"},   note_sel,   0);
    check_eq({tag, "_busy"},       busy,       0);
    check_eq({tag, "_done"},       done,       0);
    check_eq({tag, "_fail"},       fail,       0);
    check_eq({tag, "_error_code"}, error_code, 0);
    check_eq({tag, "_avail_200"},  avail_200,  NI);
    check_eq({tag, "_avail_100"},  avail_100,  NI);
    check_eq({tag, "_avail_50"},   avail_50,   NI);
  endtask

  task automatic run_txn(input int amt, input bit jam, input bit do_refill);
    int  got_seq[$];
    int  done_cnt;
    int  fail_cnt;
    int  req_hi;
    int  delay;
    int  fin_cyc;
    int  want_code;
    bit  finished;
    done_cnt = 0;
    fail_cnt = 0;
    req_hi   = 0;
    fin_cyc  = -1;
    finished = 1'b0;
    if (do_refill) for (int d = 0; d < 3; d++) model_avail[d] = NI;
    model_plan(amt);
    want_code = jam ? 3 : exp_code;
    if (jam) exp_seq.delete();
    delay = $urandom_range(0, 3);

    @(negedge clk);
    amount       = BW'(amt);
    dispense_req = 1'b1;
`ifdef DISP_REFILL_EN
    refill = do_refill;
`endif
    @(negedge clk);
    dispense_req = 1'b0;
`ifdef DISP_REFILL_EN
    refill = 1'b0;
`endif
    check_eq("busy_after_accept", busy, 1);

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (done) begin done_cnt++; finished = 1'b1; fin_cyc = cyc; end
      if (fail) begin fail_cnt++; finished = 1'b1; fin_cyc = cyc; end
      if (note_ack) begin
        note_ack = 1'b0;
      end else if (note_req) begin
        req_hi++;
        if (!jam && delay == 0) begin
          note_ack = 1'b1;
          got_seq.push_back(int'(note_sel));
          delay = $urandom_range(0, 3);
        end else if (delay > 0) begin
          delay--;
        end
      end
      if (!finished) @(negedge clk);
    end
    note_ack = 1'b0;
    check_eq("txn_completed", finished, 1);
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (fail) fail_cnt++;
    end

    check_eq("done_pulses", done_cnt, (want_code == 0) ? 1 : 0);
    check_eq("fail_pulses", fail_cnt, (want_code == 0) ? 0 : 1);
    check_eq("error_code", error_code, want_code);
    check_eq("busy_after_end", busy, 0);
    check_eq("notes_delivered", got_seq.size(), exp_seq.size());
    if (got_seq.size() == exp_seq.size())
      foreach (exp_seq[i]) check_eq("note_sel_order", got_seq[i], exp_seq[i]);
    if (want_code == 1) check_eq("bad_amount_within_2", (fin_cyc >= 0 && fin_cyc <= 2), 1);
    if (jam) check_eq("jam_req_high_cycles", req_hi, TMO);
    if (want_code == 0) foreach (exp_seq[i]) model_avail[exp_seq[i]]--;
    check_stock("stock");
  endtask

  initial begin
    int sel;
    int amt;
    dispense_req = 1'b0;
    amount       = '0;
    note_ack     = 1'b0;
`ifdef DISP_REFILL_EN
    refill       = 1'b0;
`endif
    for (int d = 0; d < 3; d++) model_avail[d] = NI;

    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;

    run_txn(350, 0, 0);
    run_txn(0, 0, 0);
    run_txn(2050, 0, 0);
    run_txn(30, 0, 0);

    repeat (9) run_txn(2000, 0, 0);
    run_txn(1600, 0, 0);
    check_eq("drained_avail_200", avail_200, 1);
    run_txn(600, 0, 0);
    check_eq("avail_200_exhausted", avail_200, 0);

    run_txn(100, 1, 0);
    run_txn(50, 0, 0);

    // Abort mid-dispense: one note acked, then reset must restore everything.
    model_plan(400);
    @(negedge clk);
    amount       = BW'(400);
    dispense_req = 1'b1;
    @(negedge clk);
    dispense_req = 1'b0;
    for (int cyc = 0; cyc < 100 && !note_req; cyc++) @(negedge clk);
    check_eq("mid_rst_note_req", note_req, 1);
    sel      = int'(note_sel);
    note_ack = 1'b1;
    @(negedge clk);
    note_ack = 1'b0;
    check_eq("mid_rst_first_debit", dut_avail(sel), model_avail[sel] - 1);
    rst = 1'b0;
    #1;
    check_reset_state("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) model_avail[d] = NI;
    run_txn(250, 0, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) amt = $urandom_range(0, 2100);
      else                           amt = 50 * $urandom_range(0, 42);
      run_txn(amt, 0, 0);
    end

`ifdef DISP_REFILL_EN
    run_txn(2000, 0, 0);
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    for (int d = 0; d < 3; d++) model_avail[d] = NI;
    check_stock("refill");
    repeat (10) run_txn(2000, 0, 0);
    run_txn(400, 0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
